// File: rtl/psum_deskew_collector_pkg.sv
// -----------------------------------------------------------------------------
// psum_deskew_collector_pkg
//   Shared constants and helpers for the partial-sum deskew collector and its
//   result FIFO.
//
//   Contents
//     NUM_DEFAULT          default array column count
//     SUM_W_DEFAULT        default partial-sum width per column
//     LAT0_DEFAULT         default inject-to-column-0 latency (array depth)
//     FIFO_DEPTH_DEFAULT   default number of buffered aligned vectors
//     clog2()              ceiling log2, usable in constant expressions
//     IN_FLIGHT_W_DEFAULT  in_flight counter width for the default sizing
// -----------------------------------------------------------------------------
package psum_deskew_collector_pkg;

   localparam int NUM_DEFAULT        = 16;
   localparam int SUM_W_DEFAULT      = 64;
   localparam int LAT0_DEFAULT       = 16;
   localparam int FIFO_DEPTH_DEFAULT = 4;

   // Smallest r with 2**r >= value; 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Holds 0 .. LAT0+NUM inclusive, enough for every vector that can be
   // between injection and the FIFO at once.
   localparam int IN_FLIGHT_W_DEFAULT = clog2(LAT0_DEFAULT + NUM_DEFAULT + 1);

endpackage : psum_deskew_collector_pkg

// File: rtl/psum_fifo.sv
// -----------------------------------------------------------------------------
// psum_fifo
//   Synchronous FIFO for aligned result vectors. Head entry is read straight
//   from the storage registers, so data written into an empty FIFO is visible
//   the cycle after the write.
//
//   Ports
//     CLK        in   1      clock, rising edge
//     RESET      in   1      asynchronous, active-high; empties FIFO, zeroes storage
//     push       in   1      write push_data (accepted when not full, or when a
//                            pop happens in the same cycle)
//     push_data  in   WIDTH  vector to store
//     pop        in   1      remove head entry (ignored when empty)
//     head_data  out  WIDTH  entry at the read pointer
//     count      out  CW     number of stored entries
//     full       out  1      count == DEPTH
//     empty      out  1      count == 0
// -----------------------------------------------------------------------------
module psum_fifo
   import psum_deskew_collector_pkg::*;
#(
   parameter  int WIDTH = NUM_DEFAULT * SUM_W_DEFAULT,
   parameter  int DEPTH = FIFO_DEPTH_DEFAULT,   // power of two, >= 2
   localparam int AW    = clog2(DEPTH),
   localparam int CW    = clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [CW-1:0]    count_next;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A pop frees the slot the same cycle, so a full FIFO still accepts a push
   // when it is also being drained.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head_data = mem[rd_ptr];

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // NOTE: storage is reset as well because head_data is an output that
         // must read as zero after reset; without that requirement the data
         // array could stay unreset and only the pointers/count cleared.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         count <= count_next;
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            // Power-of-two depth: pointer wraps by natural overflow.
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

endmodule : psum_fifo

// File: rtl/psum_deskew_collector.sv
// -----------------------------------------------------------------------------
// psum_deskew_collector
//   Sits under the last PE row of the systolic array. Column c of result
//   vector k arrives on in_sum c EN-cycles after column 0, so column c is
//   delayed by NUM-1-c EN-cycles to line every column up. A shadow pipe of
//   the vec_inject strobe marks the EN-cycle in which a complete aligned
//   vector is present; that vector is pushed into a small FIFO that feeds the
//   writeback over valid/ready. credit_ok tells the feeder whether one more
//   injection is guaranteed to find a free FIFO slot.
//
//   Ports
//     CLK        in   1          clock, rising edge
//     RESET      in   1          asynchronous, active-high; clears all state
//     EN         in   1          array advance enable
//     vec_inject in   1          feeder injected a vector this EN-cycle
//     in_sum     in   NUM*SUM_W  bottom-row partial sums, column c at [c*SUM_W +: SUM_W]
//     out_data   out  NUM*SUM_W  aligned vector at FIFO head
//     out_valid  out  1          FIFO non-empty
//     out_ready  in   1          downstream takes out_data when out_valid & out_ready
//     credit_ok  out  1          free FIFO entries exceed vectors in flight
//     in_flight  out  IFW        injected vectors not yet pushed
//     overflow   out  1          sticky: an aligned vector was dropped on a full FIFO
// -----------------------------------------------------------------------------
module psum_deskew_collector
   import psum_deskew_collector_pkg::*;
#(
   parameter  int NUM        = NUM_DEFAULT,
   parameter  int SUM_W      = SUM_W_DEFAULT,
   parameter  int LAT0       = LAT0_DEFAULT,        // >= 1
   parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,  // power of two, >= 2
   localparam int IFW        = clog2(LAT0 + NUM + 1)
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 EN,
   input  logic                 vec_inject,
   input  logic [NUM*SUM_W-1:0] in_sum,
   output logic [NUM*SUM_W-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 credit_ok,
   output logic [IFW-1:0]       in_flight,
   output logic                 overflow
);

   // EN-cycles from injection until the whole vector is aligned.
   localparam int PIPE_LEN = LAT0 + NUM - 1;
   localparam int CW       = clog2(FIFO_DEPTH + 1);

   logic [NUM*SUM_W-1:0] aligned;
   logic [PIPE_LEN-1:0]  valid_pipe;
   logic                 inject_accepted;
   logic                 push;
   logic                 pop;
   logic [CW-1:0]        fifo_count;
   logic                 fifo_full;
   logic                 fifo_empty;

   // ---------------------------------------------------------------------------
   // Deskew triangle: column c is held back NUM-1-c EN-cycles. The last column
   // arrives last and is used directly.
   // ---------------------------------------------------------------------------
   for (genvar c = 0; c < NUM; c++) begin : g_col
      localparam int DLY = NUM - 1 - c;

      if (DLY == 0) begin : g_pass
         assign aligned[c*SUM_W +: SUM_W] = in_sum[c*SUM_W +: SUM_W];
      end else begin : g_dly
         logic [SUM_W-1:0] stage [DLY];

         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               for (int i = 0; i < DLY; i++) begin
                  stage[i] <= '0;
               end
            end else if (EN) begin
               stage[0] <= in_sum[c*SUM_W +: SUM_W];
               for (int i = 1; i < DLY; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign aligned[c*SUM_W +: SUM_W] = stage[DLY-1];
      end
   end

   // ---------------------------------------------------------------------------
   // Valid pipe: the inject strobe travels alongside the data. When it reaches
   // the tail in an EN-cycle, column 0 of that vector is leaving its delay line
   // and the last column is on in_sum, i.e. `aligned` is complete.
   // ---------------------------------------------------------------------------
   assign inject_accepted = EN & vec_inject;
   assign push            = EN & valid_pipe[PIPE_LEN-1];

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         valid_pipe <= '0;
      end else if (EN) begin
         valid_pipe <= {valid_pipe[PIPE_LEN-2:0], vec_inject};
      end
   end

   // ---------------------------------------------------------------------------
   // In-flight accounting: a vector leaves the count when it reaches the FIFO
   // write port, whether or not the FIFO had room for it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         in_flight <= '0;
      end else begin
         case ({inject_accepted, push})
            2'b10:   in_flight <= in_flight + IFW'(1);
            2'b01:   in_flight <= in_flight - IFW'(1);
            default: in_flight <= in_flight;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Result FIFO and handshake.
   // ---------------------------------------------------------------------------
   assign pop       = out_valid & out_ready;
   assign out_valid = ~fifo_empty;

   psum_fifo #(
      .WIDTH (NUM * SUM_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK       (CLK),
      .RESET     (RESET),
      .push      (push),
      .push_data (aligned),
      .pop       (pop),
      .head_data (out_data),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A push on a full FIFO is only lost when no pop frees a slot that cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         overflow <= 1'b0;
      end else if (push & fifo_full & ~pop) begin
         overflow <= 1'b1;
      end
   end

   // Every in-flight vector will be pushed eventually, so another injection is
   // safe only if the free slots strictly outnumber them.
   assign credit_ok = (FIFO_DEPTH - int'(fifo_count)) > int'(in_flight);

endmodule : psum_deskew_collector

// File: tb/tb_psum_deskew_collector.sv
// -----------------------------------------------------------------------------
// tb_psum_deskew_collector
//   Directed scenarios plus a randomized phase for psum_deskew_collector with
//   NUM=4, SUM_W=16, LAT0=3, FIFO_DEPTH=4. The reference model schedules each
//   injected vector's columns onto in_sum at EN-cycle t+LAT0+c, predicts its
//   arrival at the FIFO at EN-cycle t+LAT0+NUM-1, and keeps the FIFO as a queue.
// -----------------------------------------------------------------------------
module tb_psum_deskew_collector;

   localparam int NUM        = 4;
   localparam int SUM_W      = 16;
   localparam int LAT0       = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int L          = LAT0 + NUM - 1;
   localparam int IFW        = psum_deskew_collector_pkg::clog2(LAT0 + NUM + 1);
   localparam int HORIZON    = 4096;

   logic                 CLK = 1'b0;
   logic                 RESET;
   logic                 EN;
   logic                 vec_inject;
   logic [NUM*SUM_W-1:0] in_sum;
   logic [NUM*SUM_W-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 credit_ok;
   logic [IFW-1:0]       in_flight;
   logic                 overflow;

   psum_deskew_collector #(
      .NUM        (NUM),
      .SUM_W      (SUM_W),
      .LAT0       (LAT0),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .EN         (EN),
      .vec_inject (vec_inject),
      .in_sum     (in_sum),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .credit_ok  (credit_ok),
      .in_flight  (in_flight),
      .overflow   (overflow)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model state ----------------
   bit          col_has  [0:HORIZON-1][0:NUM-1];
   logic [15:0] col_val  [0:HORIZON-1][0:NUM-1];
   bit          push_at  [0:HORIZON-1];
   logic [63:0] push_vec [0:HORIZON-1];
   logic [63:0] q [$];
   int          ecnt;
   int          in_flight_m;
   bit          ovf_m;
   bit          fixed_junk;

   int n_asserts = 0;
   int n_fail    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mkvec(input int k, input int base);
      logic [63:0] v;
      for (int c = 0; c < NUM; c++) begin
         v[c*16 +: 16] = 16'(base + 16*k + c);
      end
      return v;
   endfunction

   function automatic bit model_credit();
      return (FIFO_DEPTH - q.size()) > in_flight_m;
   endfunction

   task automatic model_clear();
      for (int e = 0; e < HORIZON; e++) begin
         push_at[e] = 1'b0;
         for (int c = 0; c < NUM; c++) begin
            col_has[e][c] = 1'b0;
         end
      end
      q.delete();
      in_flight_m = 0;
      ovf_m       = 1'b0;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ":valid"},     64'(out_valid), 64'(q.size() > 0));
      check({tag, ":in_flight"}, 64'(in_flight), 64'(in_flight_m));
      check({tag, ":overflow"},  64'(overflow),  64'(ovf_m));
      check({tag, ":credit"},    64'(credit_ok), 64'(model_credit()));
      if (q.size() > 0) begin
         check({tag, ":data"}, out_data, q[0]);
      end
   endtask

   // One clock cycle: drive inputs, clock, update model, compare.
   task automatic tick(input bit en, input bit inj, input bit rdy, input logic [63:0] vec,
                       input string tag);
      logic [63:0] s;
      bit          pop_m;
      bit          push_m;
      EN         = en;
      vec_inject = inj;
      out_ready  = rdy;
      if (en && inj) begin
         for (int c = 0; c < NUM; c++) begin
            col_has[ecnt + LAT0 + c][c] = 1'b1;
            col_val[ecnt + LAT0 + c][c] = vec[c*16 +: 16];
         end
         push_at[ecnt + L]  = 1'b1;
         push_vec[ecnt + L] = vec;
      end
      for (int c = 0; c < NUM; c++) begin
         if (col_has[ecnt][c]) s[c*16 +: 16] = col_val[ecnt][c];
         else                  s[c*16 +: 16] = fixed_junk ? 16'hDEAD : 16'($urandom);
      end
      in_sum = s;
      @(posedge CLK);
      #1;
      pop_m  = (q.size() > 0) && rdy;
      push_m = en && push_at[ecnt];
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
         if (q.size() < FIFO_DEPTH) q.push_back(push_vec[ecnt]);
         else                       ovf_m = 1'b1;
      end
      in_flight_m = in_flight_m + int'(en && inj) - int'(push_m);
      if (en) ecnt++;
      compare_all(tag);
   endtask

   task automatic do_reset(input string tag);
      EN         = 1'b0;
      vec_inject = 1'b0;
      out_ready  = 1'b0;
      in_sum     = '0;
      RESET      = 1'b1;
      model_clear();
      #1;
      check({tag, ":rst_valid"},     64'(out_valid), 64'd0);
      check({tag, ":rst_in_flight"}, 64'(in_flight), 64'd0);
      check({tag, ":rst_data"},      out_data,       64'd0);
      check({tag, ":rst_credit"},    64'(credit_ok), 64'd1);
      check({tag, ":rst_overflow"},  64'(overflow),  64'd0);
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   initial begin
      int          first;
      int          nvalid;
      logic [63:0] cap;
      logic [63:0] seen [$];
      bit          en;
      bit          inj;

      ecnt       = 0;
      fixed_junk = 1'b1;
      RESET      = 1'b1;
      EN         = 1'b0;
      vec_inject = 1'b0;
      out_ready  = 1'b0;
      in_sum     = '0;
      #3;
      do_reset("reset0");

      // ---- 1: single vector, junk 0xDEAD everywhere else ----
      tick(1, 1, 1, mkvec(0, 100), "t1");
      repeat (5) tick(1, 0, 1, '0, "t1");
      check("t1_not_early", 64'(out_valid), 64'd0);
      tick(1, 0, 1, '0, "t1");
      check("t1_valid_at_7", 64'(out_valid), 64'd1);
      check("t1_data", out_data, 64'h0067_0066_0065_0064);
      repeat (3) tick(1, 0, 1, '0, "t1_idle");

      // ---- 2: four back-to-back vectors, drained in consecutive cycles ----
      fixed_junk = 1'b0;
      seen.delete();
      first = 0;
      for (int i = 1; i <= 16; i++) begin
         tick(1, i <= 4, 1, mkvec(i - 1, 0), "t2");
         if (out_valid) begin
            if (seen.size() == 0) first = i;
            seen.push_back(out_data);
         end
      end
      check("t2_count", 64'(seen.size()), 64'd4);
      check("t2_first_cycle", 64'(first), 64'd7);
      for (int k = 0; k < 4 && k < seen.size(); k++) begin
         check("t2_order", seen[k], mkvec(k, 0));
      end
      check("t2_in_flight_zero", 64'(in_flight), 64'd0);

      // ---- 3: EN low for 5 cycles mid-flight delays output by exactly 5 ----
      first = 0;
      cap   = '0;
      for (int i = 1; i <= 20; i++) begin
         en = !(i >= 4 && i <= 8);
         tick(en, i == 1, 1, mkvec(0, 200), "t3");
         if (out_valid && first == 0) begin
            first = i;
            cap   = out_data;
         end
      end
      check("t3_delay", 64'(first), 64'd12);
      check("t3_data", cap, 64'h00CB_00CA_00C9_00C8);

      // ---- 4: backpressure, credit drop, forced overflow ----
      do_reset("t4");
      for (int i = 1; i <= 4; i++) tick(1, 1, 0, mkvec(i - 1, 0), "t4_inj");
      check("t4_credit_drop", 64'(credit_ok), 64'd0);
      tick(1, 1, 0, mkvec(4, 0), "t4_force");
      repeat (9) tick(1, 0, 0, '0, "t4_wait");
      check("t4_overflow", 64'(overflow), 64'd1);
      check("t4_head", out_data, mkvec(0, 0));
      seen.delete();
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen.push_back(out_data);
         tick(1, 0, 1, '0, "t4_drain");
      end
      check("t4_pops", 64'(seen.size()), 64'd4);
      for (int k = 0; k < 4 && k < seen.size(); k++) begin
         check("t4_order", seen[k], mkvec(k, 0));
      end

      // ---- 5: full FIFO, push and pop in the same cycle ----
      do_reset("t5");
      for (int i = 1; i <= 5; i++) tick(1, 1, 0, mkvec(i - 1, 64), "t5_inj");
      repeat (5) tick(1, 0, 0, '0, "t5_wait");
      tick(1, 0, 1, '0, "t5_popush");
      check("t5_overflow", 64'(overflow), 64'd0);
      check("t5_valid", 64'(out_valid), 64'd1);
      check("t5_full_credit", 64'(credit_ok), 64'd0);
      check("t5_head", out_data, mkvec(1, 64));
      repeat (6) tick(1, 0, 1, '0, "t5_drain");

      // ---- 6: async reset with 2 in flight and 1 queued ----
      do_reset("t6_pre");
      for (int i = 1; i <= 9; i++) tick(1, i == 1 || i >= 8, 0, mkvec(i, 32), "t6");
      check("t6_in_flight_2", 64'(in_flight), 64'd2);
      check("t6_queued", 64'(out_valid), 64'd1);
      do_reset("t6");
      nvalid = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1, 0, 1, '0, "t6_after");
         if (out_valid) nvalid++;
      end
      check("t6_no_push", 64'(nvalid), 64'd0);

      // ---- randomized phase ----
      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(3) != 0);
         if (model_credit()) inj = ($urandom_range(1) == 1);
         else                inj = ($urandom_range(15) == 0);
         tick(en, inj, $urandom_range(2) != 0, {$urandom, $urandom}, "rand");
      end
      repeat (L + 8) tick(1, 0, 1, '0, "rand_drain");
      check("rand_in_flight_zero", 64'(in_flight), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_psum_deskew_collector
